// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
// The FSM state type, the NOP reset value, the RV32I major opcodes and the
// instruction field bit positions live here.
// Optional feature macro used by the fetch unit: FETCH_PREFETCH_EN.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        PREF  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    // RV32I major opcodes
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Field least-significant bit positions inside an instruction word
    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/acknowledge port.
// Handshake: the master raises imem_req with imem_addr and holds both stable
// until the slave pulses imem_ack for exactly one cycle, with imem_rdata valid
// in that same cycle. A request may be abandoned (req dropped without ack) on
// timeout or reset; the slave must tolerate that.
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_prefetch_buf.sv
// fetch_prefetch_buf: one-entry prefetch buffer (data, tag, valid) with a
// hit compare against the current PC. Clear has priority over fill.
module fetch_prefetch_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fill_en,
    input  logic [31:0] fill_addr,
    input  logic [31:0] fill_data,
    input  logic        clear,
    input  logic [31:0] lookup_addr,
    output logic        hit,
    output logic [31:0] hit_data
);

    logic        pf_valid;
    logic [31:0] pf_addr;
    logic [31:0] pf_data;

    // Buffer entry: cleared on redirect/consume/timeout, filled on prefetch ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_valid <= 1'b0;
            pf_addr  <= 32'd0;
            pf_data  <= 32'd0;
        end else if (clear) begin
            pf_valid <= 1'b0;
        end else if (fill_en) begin
            pf_valid <= 1'b1;
            pf_addr  <= fill_addr;
            pf_data  <= fill_data;
        end
    end

    assign hit      = pf_valid && (pf_addr == lookup_addr);
    assign hit_data = pf_data;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns PC and IR for the multi-cycle RV32I core. A rising edge of
// IR_Write starts a fetch from instruction memory; the returned word lands in
// IR and PC optionally advances by 4. Decoded fields are slices of IR.
// A demand fetch that sees no ack within MAX_WAIT cycles sets a sticky fault
// that only pc_load (or reset) clears.
// Optional feature macro: FETCH_PREFETCH_EN (one-entry prefetch buffer).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         IR_Write,
    input  logic         PC_Write,
    input  logic         pc_load,
    input  logic [31:0]  pc_next,
    fetch_if.master      bus,
    output logic [31:0]  pc,
    output logic [31:0]  ir,
    output logic [6:0]   opcode,
    output logic [2:0]   funct3,
    output logic [6:0]   funct7,
    output logic [4:0]   rs1,
    output logic [4:0]   rs2,
    output logic [4:0]   rd,
    output logic         ir_valid,
    output logic         fetch_busy,
    output logic         fetch_fault,
    output fetch_state_t state_dbg
);

    localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

    fetch_state_t state;
    logic         ir_write_q;
    logic         inc_pend;
    logic         req_q;
    logic [31:0]  addr_q;
    logic [7:0]   cnt;
    logic         rise;
    logic [31:0]  pc_plus4;
    logic [31:0]  pc_tgt;

    assign rise     = IR_Write & ~ir_write_q;
    assign pc_plus4 = pc + 32'd4;
    assign pc_tgt   = word_align(pc_next);

`ifdef FETCH_PREFETCH_EN
    logic        miss_pend;
    logic        addr_match;
    logic        pf_hit;
    logic        pf_fill;
    logic        pf_clear;
    logic [31:0] pf_data;
    logic [31:0] pc_after_dem;
    logic [31:0] pc_after_rise;

    assign addr_match    = (addr_q == pc);
    assign pc_after_dem  = pc_load ? pc_tgt : (inc_pend ? pc_plus4 : pc);
    assign pc_after_rise = pc_load ? pc_tgt : (PC_Write ? pc_plus4 : pc);
    assign pf_fill  = (state == PREF) && bus.imem_ack && !rise && !miss_pend && !pc_load;
    assign pf_clear = pc_load
                    || ((state == IDLE) && rise && pf_hit)
                    || ((state == PREF) && !bus.imem_ack && (cnt == CNT_LAST));

    fetch_prefetch_buf u_pf (
        .clk         (clk),
        .rst_n       (rst_n),
        .fill_en     (pf_fill),
        .fill_addr   (addr_q),
        .fill_data   (bus.imem_rdata),
        .clear       (pf_clear),
        .lookup_addr (pc),
        .hit         (pf_hit),
        .hit_data    (pf_data)
    );
`endif

    // Fetch FSM: PC/IR ownership, memory handshake, timeout and fault tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            ir          <= NOP;
            ir_valid    <= 1'b0;
            fetch_busy  <= 1'b0;
            fetch_fault <= 1'b0;
            req_q       <= 1'b0;
            addr_q      <= 32'd0;
            inc_pend    <= 1'b0;
            cnt         <= 8'd0;
            ir_write_q  <= 1'b0;
`ifdef FETCH_PREFETCH_EN
            miss_pend   <= 1'b0;
`endif
        end else begin
            ir_write_q <= IR_Write;
            case (state)
                IDLE: begin
                    if (rise) begin
`ifdef FETCH_PREFETCH_EN
                        if (pf_hit) begin
                            // Buffered word: complete at this edge, prefetch the next PC
                            ir       <= pf_data;
                            ir_valid <= 1'b1;
                            if (PC_Write) pc <= pc_plus4;
                            addr_q   <= pc_after_rise;
                            req_q    <= 1'b1;
                            cnt      <= 8'd0;
                            state    <= PREF;
                        end else
`endif
                        begin
                            ir_valid   <= 1'b0;
                            inc_pend   <= PC_Write;
                            addr_q     <= pc;
                            req_q      <= 1'b1;
                            fetch_busy <= 1'b1;
                            cnt        <= 8'd0;
                            state      <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.imem_ack) begin
                        // Ack wins over a simultaneous timeout
                        ir         <= bus.imem_rdata;
                        ir_valid   <= 1'b1;
                        fetch_busy <= 1'b0;
                        if (inc_pend) pc <= pc_plus4;
`ifdef FETCH_PREFETCH_EN
                        addr_q <= pc_after_dem;
                        cnt    <= 8'd0;
                        state  <= PREF;
`else
                        req_q  <= 1'b0;
                        state  <= IDLE;
`endif
                    end else if (cnt == CNT_LAST) begin
                        req_q       <= 1'b0;
                        fetch_busy  <= 1'b0;
                        fetch_fault <= 1'b1;
                        state       <= FAULT;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
`ifdef FETCH_PREFETCH_EN
                PREF: begin
                    if (bus.imem_ack) begin
                        if (rise && addr_match && !miss_pend) begin
                            // Prefetched word is the one being demanded
                            ir       <= bus.imem_rdata;
                            ir_valid <= 1'b1;
                            if (PC_Write) pc <= pc_plus4;
                            addr_q   <= pc_after_rise;
                            cnt      <= 8'd0;
                        end else if (rise || miss_pend) begin
                            // Wrong word: discard and go fetch the real PC
                            ir_valid   <= 1'b0;
                            if (rise) inc_pend <= PC_Write;
                            addr_q     <= pc_load ? pc_tgt : pc;
                            fetch_busy <= 1'b1;
                            cnt        <= 8'd0;
                            miss_pend  <= 1'b0;
                            state      <= WAIT;
                        end else begin
                            req_q <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (rise && addr_match && !miss_pend) begin
                        // Promote the in-flight prefetch to a demand fetch
                        ir_valid   <= 1'b0;
                        inc_pend   <= PC_Write;
                        fetch_busy <= 1'b1;
                        cnt        <= 8'd0;
                        state      <= WAIT;
                    end else begin
                        if (rise) begin
                            miss_pend <= 1'b1;
                            inc_pend  <= PC_Write;
                            ir_valid  <= 1'b0;
                        end
                        if (cnt == CNT_LAST) begin
                            if (rise || miss_pend) begin
                                addr_q     <= pc_load ? pc_tgt : pc;
                                fetch_busy <= 1'b1;
                                cnt        <= 8'd0;
                                miss_pend  <= 1'b0;
                                state      <= WAIT;
                            end else begin
                                req_q <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
`endif
                FAULT: begin
                    if (pc_load) begin
                        fetch_fault <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Redirect is accepted in every state and overrides any +4
            if (pc_load) begin
                pc       <= pc_tgt;
                inc_pend <= 1'b0;
            end
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = addr_q;
    assign state_dbg     = state;

    assign opcode = ir[OPCODE_LSB +: 7];
    assign rd     = ir[RD_LSB     +: 5];
    assign funct3 = ir[FUNCT3_LSB +: 3];
    assign rs1    = ir[RS1_LSB    +: 5];
    assign rs2    = ir[RS2_LSB    +: 5];
    assign funct7 = ir[FUNCT7_LSB +: 7];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: bench for fetch_unit in its default build. The bench plays
// instruction memory, keeps a reference model of PC/IR/flags, and a queue of
// addresses it expects to see requested.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          MW     = 15;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         IR_Write = 1'b0;
    logic         PC_Write = 1'b0;
    logic         pc_load = 1'b0;
    logic [31:0]  pc_next = 32'd0;
    logic [31:0]  pc, ir;
    logic [6:0]   opcode, funct7;
    logic [2:0]   funct3;
    logic [4:0]   rs1, rs2, rd;
    logic         ir_valid, fetch_busy, fetch_fault;
    fetch_state_t state_dbg;

    fetch_if bus ();

    fetch_unit #(.RESET_PC(RST_PC), .MAX_WAIT(MW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .IR_Write   (IR_Write),
        .PC_Write   (PC_Write),
        .pc_load    (pc_load),
        .pc_next    (pc_next),
        .bus        (bus),
        .pc         (pc),
        .ir         (ir),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .ir_valid   (ir_valid),
        .fetch_busy (fetch_busy),
        .fetch_fault(fetch_fault),
        .state_dbg  (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard and model state
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    int          txn_cnt = 0;
    logic        req_prev = 1'b0;
    logic [31:0] held_addr = 32'd0;
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic        m_valid;
    logic        m_fault;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock, then sample 1 time unit later and watch the memory port
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.imem_req && !req_prev) begin
            check("req_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) check("req_addr", bus.imem_addr, exp_q.pop_front());
            txn_cnt++;
            held_addr = bus.imem_addr;
        end else if (bus.imem_req && req_prev) begin
            check("addr_stable", bus.imem_addr, held_addr);
        end
        req_prev = bus.imem_req;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_pc"},     pc,                  m_pc);
        check({tag, "_ir"},     ir,                  m_ir);
        check({tag, "_valid"},  {31'd0, ir_valid},   {31'd0, m_valid});
        check({tag, "_fault"},  {31'd0, fetch_fault},{31'd0, m_fault});
        check({tag, "_busy"},   {31'd0, fetch_busy}, 32'd0);
        check({tag, "_opcode"}, {25'd0, opcode},     m_ir % 128);
        check({tag, "_rd"},     {27'd0, rd},         (m_ir / 128) % 32);
        check({tag, "_funct3"}, {29'd0, funct3},     (m_ir / 4096) % 8);
        check({tag, "_rs1"},    {27'd0, rs1},        (m_ir / 32768) % 32);
        check({tag, "_rs2"},    {27'd0, rs2},        (m_ir / 1048576) % 32);
        check({tag, "_funct7"}, {25'd0, funct7},     m_ir / 33554432);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        IR_Write = 1'b0;
        PC_Write = 1'b0;
        pc_load = 1'b0;
        pc_next = 32'd0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_pc = RST_PC;
        m_ir = 32'h0000_0013;
        m_valid = 1'b0;
        m_fault = 1'b0;
        exp_q.delete();
        req_prev = 1'b0;
        check("rst_req",   {31'd0, bus.imem_req}, 32'd0);
        check("rst_addr",  bus.imem_addr, 32'd0);
        check("rst_state", {30'd0, state_dbg}, {30'd0, IDLE});
        check_outputs("rst");
    endtask

    // Demand fetch: rise, optional redirect in wait cycle load_at, ack in wait cycle dly
    task automatic do_fetch(input logic pw, input int dly, input logic [31:0] data,
                            input int load_at, input logic [31:0] load_val);
        logic inc;
        inc = pw;
        IR_Write = 1'b0;
        tick();
        IR_Write = 1'b1;
        PC_Write = pw;
        exp_q.push_back(m_pc);
        tick();
        m_valid = 1'b0;
        check("fetch_req_on", {31'd0, bus.imem_req}, 32'd1);
        check("fetch_busy_on", {31'd0, fetch_busy}, 32'd1);
        check("fetch_valid_clr", {31'd0, ir_valid}, 32'd0);
        for (int i = 0; i < dly; i++) begin
            if (i == load_at) begin
                pc_load = 1'b1;
                pc_next = load_val;
            end
            tick();
            pc_load = 1'b0;
            if (i == load_at) begin
                m_pc = load_val & ~32'd3;
                inc = 1'b0;
                check("wait_load_pc", pc, m_pc);
            end
            check("wait_req", {31'd0, bus.imem_req}, 32'd1);
        end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = data;
        tick();
        bus.imem_ack = 1'b0;
        bus.imem_rdata = $urandom;
        m_ir = data;
        m_valid = 1'b1;
        if (inc) m_pc = m_pc + 32'd4;
        check("done_req_off", {31'd0, bus.imem_req}, 32'd0);
        check_outputs("done");
    endtask

    task automatic do_load(input logic [31:0] val);
        pc_load = 1'b1;
        pc_next = val;
        tick();
        pc_load = 1'b0;
        m_pc = val & ~32'd3;
        m_fault = 1'b0;
        check_outputs("load");
    endtask

    initial begin
        int t0;
        reset_dut();

        // Basic fetch: addi x1, x0, 5 at 0x100, ack after 3 wait cycles
        do_fetch(1'b1, 3, 32'h0050_0093, -1, 32'd0);
        check("tp_ir",     ir, 32'h0050_0093);
        check("tp_opcode", {25'd0, opcode}, 32'h13);
        check("tp_rd",     {27'd0, rd}, 32'd1);
        check("tp_pc",     pc, 32'h104);

        // Minimum and maximum ack latencies (ack in last wait cycle beats timeout)
        do_fetch(1'b1, 0, 32'h0000_00b3, -1, 32'd0);
        do_fetch(1'b0, MW - 1, 32'h4020_8133, -1, 32'd0);

        // Level held high: exactly one transaction
        t0 = txn_cnt;
        do_fetch(1'b0, 2, 32'h0020_8193, -1, 32'd0);
        repeat (9) tick();
        check("held_one_txn", txn_cnt - t0, 32'd1);
        check("held_req_off", {31'd0, bus.imem_req}, 32'd0);
        IR_Write = 1'b0;
        tick();

        // Timeout to FAULT, rise ignored, pc_load recovers
        IR_Write = 1'b1;
        PC_Write = 1'b1;
        exp_q.push_back(m_pc);
        tick();
        m_valid = 1'b0;
        for (int i = 0; i < MW - 1; i++) begin
            tick();
            check("to_no_fault", {31'd0, fetch_fault}, 32'd0);
            check("to_req_held", {31'd0, bus.imem_req}, 32'd1);
        end
        tick();
        m_fault = 1'b1;
        check("to_req_off", {31'd0, bus.imem_req}, 32'd0);
        check_outputs("to_fault");
        IR_Write = 1'b0;
        tick();
        IR_Write = 1'b1;
        repeat (3) tick();
        check("to_rise_ignored", {31'd0, bus.imem_req}, 32'd0);
        check("to_still_fault", {31'd0, fetch_fault}, 32'd1);
        IR_Write = 1'b0;
        do_load(32'h0000_0200);

        // Redirect during WAIT: address unchanged, no +4 at completion
        do_fetch(1'b1, 4, 32'h0000_0513, 1, 32'h0000_0203);
        check("ld_pc", pc, 32'h200);

        // Unaligned load in IDLE, then PC wrap
        do_load(32'h0000_0abf);
        do_load(32'hFFFF_FFFC);
        do_fetch(1'b1, 1, 32'h00c0_0593, -1, 32'd0);
        check("wrap_pc", pc, 32'h0);

        // Randomized fetches
        for (int n = 0; n < 30; n++) begin
            logic        pw;
            int          dly;
            int          ld;
            pw  = 1'($urandom_range(0, 1));
            dly = $urandom_range(0, MW - 1);
            ld  = -1;
            if (dly > 0 && $urandom_range(0, 3) == 0) ld = $urandom_range(0, dly - 1);
            do_fetch(pw, dly, $urandom, ld, $urandom);
            if ($urandom_range(0, 4) == 0) do_load($urandom);
        end

        // Asynchronous reset mid-transaction drops the request at once
        IR_Write = 1'b0;
        tick();
        IR_Write = 1'b1;
        exp_q.push_back(m_pc);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req_off", {31'd0, bus.imem_req}, 32'd0);
        check("arst_pc", pc, RST_PC);
        reset_dut();
        do_fetch(1'b1, 2, 32'h0010_0073, -1, 32'd0);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
